sim_ram_hs: RTL

SIM_RAM_HS -- requirements
Module: sim_ram_hs

---
 rtl/sim_ram_hs.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sim_ram_hs.sv
// Simulation RAM behind valid/ready command and response handshakes.
// Accepted commands pass through a fixed LAT-stage pipeline into a small FWFT response FIFO.
module sim_ram_hs #(
    parameter int DP           = 512,
    parameter int DW           = 32,
    parameter int MW           = 4,
    parameter int AW           = 32,
    parameter int LAT          = 1,
    parameter bit FORCE_X2ZERO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);
    localparam int LW = DW / MW;
    localparam int IW = (DP > 1) ? $clog2(DP) : 1;
    localparam int FD = LAT + 1;
    localparam int CW = $clog2(FD + 1);
    localparam int FA = 2 ** CW;

    logic [DW-1:0]  mem_q [DP];

    logic           accept;
    logic           consume;
    logic           push;
    logic           in_range;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  rd_word;

    logic [LAT-1:0] pipe_vld_q;
    logic [LAT-1:0] pipe_err_q;
    logic [DW-1:0]  pipe_data_q [LAT];

    logic [DW-1:0]  fifo_data_q [FA];
    logic [FA-1:0]  fifo_err_q;
    logic [CW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]  outst_q, outst_d;

    logic [DW-1:0]  head_data;
    logic [DW-1:0]  head_clean;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    // The outstanding count covers pipeline plus FIFO, so the FIFO can never overflow.
    assign cmd_ready = (outst_q < CW'(FD));
    assign accept    = cmd_valid && cmd_ready && !rst;
    assign push      = pipe_vld_q[LAT-1];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign consume   = rsp_valid && rsp_ready;

    assign in_range  = (cmd_addr < AW'(DP));
    assign idx       = cmd_addr[IW-1:0];
    assign rd_word   = (cmd_read && in_range) ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (accept && !cmd_read && in_range) begin
            for (int l = 0; l < MW; l++) begin
                if (cmd_wmask[l]) begin
                    mem_q[idx][l*LW +: LW] <= cmd_wdata[l*LW +: LW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                pipe_data_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= accept;
            pipe_err_q[0]  <= accept && !in_range;
            pipe_data_q[0] <= accept ? rd_word : '0;
            for (int s = 1; s < LAT; s++) begin
                pipe_vld_q[s]  <= pipe_vld_q[s-1];
                pipe_err_q[s]  <= pipe_err_q[s-1];
                pipe_data_q[s] <= pipe_data_q[s-1];
            end
        end
    end

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = consume ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push && !consume) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && consume) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
        outst_d = outst_q;
        if (accept && !consume) begin
            outst_d = outst_q + 1'b1;
        end else if (!accept && consume) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
            fifo_err_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            outst_q    <= outst_d;
            if (push) begin
                fifo_err_q[wr_ptr_q] <= pipe_err_q[LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= pipe_data_q[LAT-1];
        end
    end

    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        head_clean = head_data;
        if (FORCE_X2ZERO) begin
            for (int b = 0; b < DW; b++) begin
                head_clean[b] = (head_data[b] === 1'b1);
            end
        end
    end

    assign rsp_rdata = rsp_valid ? head_clean : '0;
    assign rsp_err   = rsp_valid && fifo_err_q[rd_ptr_q];

endmodule
